tt_sweep_reader: RTL and testbench
==================================

Name: tt_sweep_reader

Overview:
- Sequential truth-table reader for small Boolean netlists, the inverse of the exact-synthesis flow.
- A netlist realises a truth table as gates; this block recovers the truth table from a netlist instance (device under evaluation, DUE).
- It sweeps every input minterm onto the DUE inputs, samples the single DUE output, and assembles the 2^N_IN-bit truth table.
- It optionally compares the result against an expected table. It sits in the equivalence-check harness beside each generated netlist.

Parameters:
- N_IN, 4, number of DUE inputs; TT_W = 2**N_IN (16 at default).
- LAT, 0, cycles between x_out changing and y_in being valid. 0 = combinational DUE; legal range 0..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep. Sampled only in IDLE.
- cmp_en  in  1  enable comparison. Captured at start.
- exp_tt  in  TT_W  expected truth table. Captured at start; bit i = f(minterm i).
- x_out  out  N_IN  drive to DUE inputs; x_out[0] = x0 = LSB of the minterm index.
- y_in  in  1  DUE output.
- busy  out  1  high from the cycle after start through the final sample cycle.
- done  out  1  one-cycle pulse when the table is complete.
- tt_out  out  TT_W  assembled truth table. Held stable until the next accepted start.
- mismatch  out  1  tt_out != captured exp_tt, with cmp_en captured high. Valid with done; held.
- mism_cnt  out  N_IN+1  number of differing bits (0..TT_W).
- first_mism_idx  out  N_IN  lowest differing minterm index.
- first_mism_vld  out  1  first_mism_idx is meaningful.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal index and latency counter 0. Reset in any state aborts the sweep in the same clock edge, with no done pulse. Partial tt_out is cleared.
- States: IDLE, SETTLE, SAMPLE, FIN.
- IDLE:
  - start=1 captures exp_tt and cmp_en.
  - Clears tt_out, mism_cnt, mismatch and first_mism_*.
  - Sets idx=0 and x_out=0.
  - Goes to SETTLE if LAT>0, else to SAMPLE. busy=1 from the next cycle.
- SETTLE: lat counter counts LAT cycles with x_out held, then goes to SAMPLE.
- SAMPLE:
  - tt_out[idx] <= y_in.
  - If cmp_en and y_in != exp_tt[idx]: mism_cnt increments. If first_mism_vld=0, set first_mism_idx=idx and first_mism_vld=1.
  - If idx = TT_W-1, go to FIN. Otherwise idx+1, x_out <= idx+1, and go to SETTLE (LAT>0) or stay in SAMPLE (LAT=0).
- FIN (one cycle):
  - done=1, busy=0.
  - mismatch = cmp_en & (mism_cnt != 0).
  - Goes to IDLE.
- Latency: start accepted at cycle 0. Sample k occurs at cycle 1 + k*(LAT+1) + LAT. done occurs at cycle 1 + TT_W*(LAT+1). At LAT=0, N_IN=4: done at cycle 17.
- start while busy or in FIN is ignored, not queued. start in the same cycle as rst is ignored.
- Index wrap: idx never wraps; the sweep terminates at TT_W-1. mism_cnt width admits TT_W exactly, so there is no overflow.
- x_out after done holds TT_W-1 until the next start.
- cmp_en=0: mismatch, mism_cnt and first_mism_vld remain 0; tt_out is still produced.
- y_in is X/undriven: no requirement. The bench always drives it.

Decomposition:
- Shared package tt_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, FIN)
  - function tt_width(n) = 2**n
  - constant MAX_LAT = 7
  - typedef for the minterm index
- Optional sub-module tt_mism_tracker: per-sample compare, counter and first-index capture. Reusable by the multi-output variant.
- The FSM and sweep counter stay in the top module.

Test Plan:
1. N_IN=4, LAT=0, DUE y=x0&x1, exp_tt=0x8888, cmp_en=1, pulse start → done at cycle 17; tt_out=0x8888; mismatch=0; mism_cnt=0; first_mism_vld=0.
2. DUE y=x0^x1^x2^x3, exp_tt=0x6996, LAT=3 (DUE behind a 3-stage pipe) → done at cycle 65; tt_out=0x6996; mismatch=0.
3. DUE y=0, exp_tt=0x8001, cmp_en=1 → tt_out=0x0000; mismatch=1; mism_cnt=2; first_mism_idx=0; first_mism_vld=1.
4. Same as 3 with cmp_en=0 → tt_out=0x0000; mismatch=0; mism_cnt=0; first_mism_vld=0.
5. rst asserted at cycle 8 of a LAT=0 sweep → the next cycle shows all outputs 0 and state IDLE, with no done pulse. A new start then completes normally with the correct tt_out.
6. start re-pulsed at cycles 5 and 17 (the FIN cycle) during a sweep → both are ignored. Exactly one done occurs at cycle 17, and busy stays 0 afterward until the next start.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep reader: FSM states,
// width helper and the default minterm index type.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_e;

    localparam int MAX_LAT  = 7;
    localparam int DEF_N_IN = 4;

    typedef logic [DEF_N_IN-1:0] idx_t;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_sweep_reader_if.sv
// Control/status bundle between the equivalence-check harness (master)
// and the sweep reader (slave).
interface tt_sweep_reader_if #(
    parameter int N_IN = 4
);
    import tt_pkg::*;

    localparam int TT_W = tt_width(N_IN);

    logic              start;
    logic              cmp_en;
    logic [TT_W-1:0]   exp_tt;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   tt_out;
    logic              mismatch;
    logic [N_IN:0]     mism_cnt;
    logic [N_IN-1:0]   first_mism_idx;
    logic              first_mism_vld;

    modport master (
        output start, cmp_en, exp_tt,
        input  busy, done, tt_out, mismatch, mism_cnt, first_mism_idx, first_mism_vld
    );

    modport slave (
        input  start, cmp_en, exp_tt,
        output busy, done, tt_out, mismatch, mism_cnt, first_mism_idx, first_mism_vld
    );

endinterface

// File: rtl/tt_mism_tracker.sv
// Per-sample comparison against the expected bit: counts differing
// minterms and remembers the lowest differing index.
module tt_mism_tracker #(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            smp,
    input  logic            cmp_en,
    input  logic            y,
    input  logic            exp_bit,
    input  logic [N_IN-1:0] idx,
    output logic [N_IN:0]   mism_cnt,
    output logic [N_IN-1:0] first_mism_idx,
    output logic            first_mism_vld
);

    logic [N_IN:0]   cnt_q,  cnt_d;
    logic [N_IN-1:0] fidx_q, fidx_d;
    logic            fvld_q, fvld_d;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d  = cnt_q;
        fidx_d = fidx_q;
        fvld_d = fvld_q;
        if (clr) begin
            cnt_d  = '0;
            fidx_d = '0;
            fvld_d = 1'b0;
        end else if (smp && cmp_en && (y != exp_bit)) begin
            cnt_d = cnt_q + 1'b1;
            if (!fvld_q) begin
                fidx_d = idx;
                fvld_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            fidx_q <= '0;
            fvld_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fidx_q <= fidx_d;
            fvld_q <= fvld_d;
        end
    end

    assign mism_cnt       = cnt_q;
    assign first_mism_idx = fidx_q;
    assign first_mism_vld = fvld_q;

endmodule

// File: rtl/tt_sweep_reader.sv
// Sweeps every minterm onto the device under evaluation, samples its output
// after LAT settle cycles and assembles the truth table, optionally checked.
module tt_sweep_reader
    import tt_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int LAT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    tt_sweep_reader_if.slave   bus,
    output logic [N_IN-1:0]    x_out,
    input  logic               y_in
);

    localparam int                 TT_W     = tt_width(N_IN);
    localparam int                 LAT_W    = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'((LAT > 0) ? LAT - 1 : 0);
    localparam logic [N_IN-1:0]    IDX_LAST = '1;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q,   idx_d;
    logic [LAT_W-1:0]  lat_q,   lat_d;
    logic [TT_W-1:0]   tt_q,    tt_d;
    logic [TT_W-1:0]   exp_q,   exp_d;
    logic              cmp_q,   cmp_d;
    logic              clr;
    logic              smp;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        tt_d    = tt_q;
        exp_d   = exp_q;
        cmp_d   = cmp_q;
        clr     = 1'b0;
        smp     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.exp_tt;
                    cmp_d   = bus.cmp_en;
                    tt_d    = '0;
                    idx_d   = '0;
                    lat_d   = '0;
                    clr     = 1'b1;
                    state_d = (LAT > 0) ? SETTLE : SAMPLE;
                end
            end
            SETTLE: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            SAMPLE: begin
                smp         = 1'b1;
                tt_d[idx_q] = y_in;
                if (idx_q == IDX_LAST) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = (LAT > 0) ? SETTLE : SAMPLE;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over start in the same edge, so a coincident start is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lat_q   <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            cmp_q   <= cmp_d;
        end
    end

    tt_mism_tracker #(.N_IN(N_IN)) u_mism (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .smp            (smp),
        .cmp_en         (cmp_q),
        .y              (y_in),
        .exp_bit        (exp_q[idx_q]),
        .idx            (idx_q),
        .mism_cnt       (bus.mism_cnt),
        .first_mism_idx (bus.first_mism_idx),
        .first_mism_vld (bus.first_mism_vld)
    );

    // The index register doubles as the DUE drive, so it holds TT_W-1 after a sweep.
    assign x_out        = idx_q;
    assign bus.busy     = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done     = (state_q == FIN);
    assign bus.tt_out   = tt_q;
    assign bus.mismatch = cmp_q && (bus.mism_cnt != '0);

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Bench for tt_sweep_reader: a LAT=0 and a LAT=3 instance share a modelled DUE;
// directed table vectors, reset/start corner sequences and random tables.
module tb_tt_sweep_reader;
    import tt_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_sweep_reader_if #(.N_IN(4)) if0 ();
    tt_sweep_reader_if #(.N_IN(4)) if1 ();

    logic [3:0]  x0, x1;
    logic        y0, y1;
    logic [3:0]  pipe [0:2];
    int          mode;
    logic [15:0] rtt;

    tt_sweep_reader #(.N_IN(4), .LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave), .x_out(x0), .y_in(y0));
    tt_sweep_reader #(.N_IN(4), .LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .x_out(x1), .y_in(y1));

    function automatic logic due_f(input int m, input logic [3:0] x, input logic [15:0] rt);
        case (m)
            0:       return x[0] & x[1];
            1:       return ^x;
            2:       return 1'b0;
            default: return rt[x];
        endcase
    endfunction

    always @(posedge clk) begin
        pipe[0] <= x1;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end

    assign y0 = due_f(mode, x0, rtt);
    assign y1 = due_f(mode, pipe[2], rtt);

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [15:0] tt;
        logic        mm;
        logic [4:0]  cnt;
        logic [3:0]  fidx;
        logic        fvld;
        logic [3:0]  x;
    } stat_t;

    typedef struct {
        int          sel;
        int          m;
        logic [15:0] exp_tt;
        logic        cmp;
        logic [15:0] e_tt;
        logic        e_mm;
        logic [4:0]  e_cnt;
        logic [3:0]  e_fidx;
        logic        e_fvld;
        int          e_done;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stat_t rd(input int sel);
        stat_t s;
        if (sel == 0)
            s = '{if0.busy, if0.done, if0.tt_out, if0.mismatch, if0.mism_cnt, if0.first_mism_idx, if0.first_mism_vld, x0};
        else
            s = '{if1.busy, if1.done, if1.tt_out, if1.mismatch, if1.mism_cnt, if1.first_mism_idx, if1.first_mism_vld, x1};
        return s;
    endfunction

    task automatic drive(input int sel, input logic s, input logic c, input logic [15:0] e);
        if (sel == 0) begin
            if0.start = s; if0.cmp_en = c; if0.exp_tt = e;
        end else begin
            if1.start = s; if1.cmp_en = c; if1.exp_tt = e;
        end
    endtask

    // Start at cycle 0, return the cycle of the done pulse (-1 on timeout) and busy cycle count.
    task automatic sweep(input int sel, input logic [15:0] e, input logic c, output int dcyc, output int bcnt);
        stat_t st;
        @(negedge clk);
        drive(sel, 1'b1, c, e);
        @(posedge clk);
        #1 drive(sel, 1'b0, c, e);
        dcyc = -1;
        bcnt = 0;
        for (int n = 1; n <= 200 && dcyc < 0; n++) begin
            @(negedge clk);
            st = rd(sel);
            if (st.done) dcyc = n;
            else if (st.busy) bcnt++;
        end
    endtask

    task automatic check_result(input string tag, input int sel, input int dcyc, input int bcnt,
                                input int e_done, input logic [15:0] e_tt, input logic e_mm,
                                input logic [4:0] e_cnt, input logic [3:0] e_fidx, input logic e_fvld);
        stat_t st;
        st = rd(sel);
        check({tag, " done_cycle"}, 64'(dcyc), 64'(e_done));
        check({tag, " busy_cycles"}, 64'(bcnt), 64'(e_done - 1));
        check({tag, " tt_out"}, 64'(st.tt), 64'(e_tt));
        check({tag, " mismatch"}, 64'(st.mm), 64'(e_mm));
        check({tag, " mism_cnt"}, 64'(st.cnt), 64'(e_cnt));
        check({tag, " first_idx"}, 64'(st.fidx), 64'(e_fidx));
        check({tag, " first_vld"}, 64'(st.fvld), 64'(e_fvld));
        check({tag, " x_hold"}, 64'(st.x), 64'(15));
        @(negedge clk);
        st = rd(sel);
        check({tag, " done_pulse"}, 64'({st.done, st.busy}), 64'(0));
    endtask

    vec_t vecs [5];

    initial begin
        stat_t       st;
        int          dcyc, bcnt, dcnt, dfirst, bafter;
        logic [15:0] e, diff;
        logic        c;
        int          sel, lat, kind;
        logic [4:0]  m_cnt;
        logic [3:0]  m_fidx;
        logic        m_fvld;

        vecs[0] = '{0, 0, 16'h8888, 1'b1, 16'h8888, 1'b0, 5'd0, 4'd0, 1'b0, 17};
        vecs[1] = '{1, 1, 16'h6996, 1'b1, 16'h6996, 1'b0, 5'd0, 4'd0, 1'b0, 65};
        vecs[2] = '{0, 2, 16'h8001, 1'b1, 16'h0000, 1'b1, 5'd2, 4'd0, 1'b1, 17};
        vecs[3] = '{0, 2, 16'h8001, 1'b0, 16'h0000, 1'b0, 5'd0, 4'd0, 1'b0, 17};
        vecs[4] = '{1, 2, 16'h8001, 1'b1, 16'h0000, 1'b1, 5'd2, 4'd0, 1'b1, 65};

        mode = 0;
        rtt  = '0;
        rst  = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state dut0", 64'(rd(0)), 64'(0));
        check("reset_state dut1", 64'(rd(1)), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].m;
            sweep(vecs[i].sel, vecs[i].exp_tt, vecs[i].cmp, dcyc, bcnt);
            check_result($sformatf("vec%0d", i), vecs[i].sel, dcyc, bcnt, vecs[i].e_done, vecs[i].e_tt,
                         vecs[i].e_mm, vecs[i].e_cnt, vecs[i].e_fidx, vecs[i].e_fvld);
        end

        // Reset in the middle of a LAT=0 sweep.
        mode = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h0000);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b1, 16'h0000);
        repeat (8) @(negedge clk);
        st = rd(0);
        check("midsweep tt_out", 64'(st.tt), 64'(16'h0008));
        check("midsweep mism_cnt", 64'(st.cnt), 64'(1));
        check("midsweep first_idx", 64'(st.fidx), 64'(3));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort all_zero", 64'(rd(0)), 64'(0));
        dcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rd(0).done) dcnt++;
        end
        check("abort no_done", 64'(dcnt), 64'(0));
        sweep(0, 16'h8888, 1'b1, dcyc, bcnt);
        check_result("after_abort", 0, dcyc, bcnt, 17, 16'h8888, 1'b0, 5'd0, 4'd0, 1'b0);

        // Start coincident with reset is dropped.
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h1234);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 1'b0, 1'b1, 16'h1234);
        @(negedge clk);
        st = rd(0);
        check("start_with_rst busy", 64'({st.busy, st.x}), 64'(0));
        @(negedge clk);
        check("start_with_rst idle", 64'(rd(0).busy), 64'(0));

        // Restarts during the sweep and in the FIN cycle are ignored.
        mode = 1;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h6996);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b1, 16'h6996);
        dcnt = 0; dfirst = -1; bafter = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            st = rd(0);
            if (st.done) begin
                dcnt++;
                if (dfirst < 0) dfirst = n;
            end
            if (n > 17 && st.busy) bafter++;
            drive(0, (n == 5 || n == 17), 1'b1, 16'h6996);
        end
        check("restart done_count", 64'(dcnt), 64'(1));
        check("restart done_cycle", 64'(dfirst), 64'(17));
        check("restart busy_after", 64'(bafter), 64'(0));
        check("restart tt_held", 64'(rd(0).tt), 64'(16'h6996));
        check("restart x_held", 64'(rd(0).x), 64'(15));

        // Random tables against a reference derived from the comparison rules.
        mode = 3;
        for (int i = 0; i < 20; i++) begin
            sel  = int'($urandom_range(0, 1));
            lat  = (sel == 0) ? 0 : 3;
            rtt  = 16'($urandom);
            kind = int'($urandom_range(0, 2));
            case (kind)
                0:       e = rtt;
                1:       e = rtt ^ (16'h1 << $urandom_range(0, 15));
                default: e = 16'($urandom);
            endcase
            c      = 1'($urandom_range(0, 1));
            diff   = rtt ^ e;
            m_cnt  = '0;
            m_fidx = '0;
            m_fvld = 1'b0;
            if (c) begin
                for (int b = 15; b >= 0; b--) begin
                    if (diff[b]) begin
                        m_cnt  = m_cnt + 1'b1;
                        m_fidx = 4'(b);
                        m_fvld = 1'b1;
                    end
                end
            end
            sweep(sel, e, c, dcyc, bcnt);
            check_result($sformatf("rand%0d", i), sel, dcyc, bcnt, 1 + 16 * (lat + 1), rtt,
                         m_fvld, m_cnt, m_fidx, m_fvld);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
